// File: rtl/match_run_logger_if.sv
// Interface for the match run logger: detector input, FIFO pop and status outputs.
// The slave modport faces the logger; the master modport faces the upstream/consumer side.
interface match_run_logger_if #(
    parameter int unsigned LEN_W = 8
);
    logic             match_in;
    logic             rd_en;
    logic [LEN_W-1:0] run_len;
    logic             run_valid;
    logic             fifo_full;
    logic             overflow;
    logic [LEN_W-1:0] run_count;

    modport master (
        output match_in,
        output rd_en,
        input  run_len,
        input  run_valid,
        input  fifo_full,
        input  overflow,
        input  run_count
    );

    modport slave (
        input  match_in,
        input  rd_en,
        output run_len,
        output run_valid,
        output fifo_full,
        output overflow,
        output run_count
    );
endinterface

// File: rtl/match_run_logger.sv
// Measures the length of each run of match_in=1 and queues completed run lengths
// in a small FIFO, with a sticky drop flag and a saturating total-run counter.
module match_run_logger #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input logic               clk,
    input logic               reset,
    match_run_logger_if.slave bus
);
    localparam int unsigned      PtrW    = $clog2(DEPTH);
    localparam logic [PtrW:0]    FullCnt = (PtrW + 1)'(DEPTH);
    localparam logic [LEN_W-1:0] LenMax  = '1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]    occ_q, occ_d;
    logic [LEN_W-1:0] count_q;
    logic             overflow_q;
    logic             push, pop, store, empty, full;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.match_in) begin
                    state_d = StRun;
                    len_d   = LEN_W'(1);
                end else begin
                    len_d = '0;
                end
            end
            StRun: begin
                if (bus.match_in) begin
                    if (len_q != LenMax) len_d = len_q + 1'b1;
                end else begin
                    state_d = StIdle;
                    len_d   = '0;
                    push    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        empty = (occ_q == '0);
        full  = (occ_q == FullCnt);
        pop   = bus.rd_en && !empty;
        store = push && (!full || pop);
        unique case ({store, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            occ_q   <= occ_d;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (push && count_q != LenMax) count_q <= count_q + 1'b1;
            if (push && !store) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr_q] <= len_q;
    end

    assign bus.run_len   = empty ? '0 : mem[rd_ptr_q];
    assign bus.run_valid = !empty;
    assign bus.fifo_full = full;
    assign bus.overflow  = overflow_q;
    assign bus.run_count = count_q;
endmodule

// File: tb/tb_match_run_logger.sv
// Bench for match_run_logger: vector table, directed corner sequences and random
// traffic checked against a queue-based model of runs and the FIFO.
module tb_match_run_logger;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = 8;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic clk;
    logic reset;
    match_run_logger_if #(.LEN_W(LEN_W)) bus ();

    match_run_logger #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a run is "active" with a length; completed runs go to a queue.
    int m_q[$];
    bit m_in_run;
    int m_len;
    int m_runs;
    bit m_ovf;

    typedef struct {
        bit m;
        bit rd;
        bit ev;
        int el;
        int ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in_run = 1'b0;
        m_len    = 0;
        m_runs   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input bit m, input bit rd);
        bit pop, push, fits;
        int done_len;
        pop      = rd && (m_q.size() > 0);
        push     = m_in_run && !m;
        done_len = m_len;
        fits     = (m_q.size() < DEPTH) || pop;
        if (m_in_run) begin
            if (m) m_len = (m_len < LEN_MAX) ? m_len + 1 : LEN_MAX;
            else begin
                m_in_run = 1'b0;
                m_len    = 0;
            end
        end else if (m) begin
            m_in_run = 1'b1;
            m_len    = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_runs < LEN_MAX) m_runs++;
            if (fits) m_q.push_back(done_len);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".run_valid"}, 32'(bus.run_valid), 32'(m_q.size() > 0));
        chk({tag, ".run_len"}, 32'(bus.run_len), (m_q.size() > 0) ? m_q[0] : 0);
        chk({tag, ".fifo_full"}, 32'(bus.fifo_full), 32'(m_q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".run_count"}, 32'(bus.run_count), m_runs);
    endtask

    task automatic step(input bit m, input bit rd, input string tag);
        bus.match_in = m;
        bus.rd_en    = rd;
        @(posedge clk);
        model_edge(m, rd);
        #1;
        compare_model(tag);
    endtask

    task automatic run(input int n, input bit rd_at_end, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, tag);
        step(1'b0, rd_at_end, tag);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        chk({tag, ".rst_valid"}, 32'(bus.run_valid), 0);
        chk({tag, ".rst_len"}, 32'(bus.run_len), 0);
        chk({tag, ".rst_full"}, 32'(bus.fifo_full), 0);
        chk({tag, ".rst_ovf"}, 32'(bus.overflow), 0);
        chk({tag, ".rst_count"}, 32'(bus.run_count), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        reset        = 1'b0;
        bus.match_in = 1'b0;
        bus.rd_en    = 1'b0;
        model_reset();
        #12;
        apply_reset("init");

        // Three-cycle run, then pop it.
        vecs[0] = '{m: 1'b1, rd: 1'b0, ev: 1'b0, el: 0, ec: 0};
        vecs[1] = '{m: 1'b1, rd: 1'b0, ev: 1'b0, el: 0, ec: 0};
        vecs[2] = '{m: 1'b1, rd: 1'b0, ev: 1'b0, el: 0, ec: 0};
        vecs[3] = '{m: 1'b0, rd: 1'b0, ev: 1'b1, el: 3, ec: 1};
        vecs[4] = '{m: 1'b0, rd: 1'b1, ev: 1'b0, el: 0, ec: 1};
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].m, vecs[i].rd, "vec");
            chk($sformatf("vec%0d.valid", i), 32'(bus.run_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d.len", i), 32'(bus.run_len), vecs[i].el);
            chk($sformatf("vec%0d.count", i), 32'(bus.run_count), vecs[i].ec);
        end

        // Five runs into a four-entry FIFO with no reads.
        apply_reset("ovf");
        for (int n = 1; n <= 5; n++) run(n, 1'b0, "ovf");
        chk("ovf.full", 32'(bus.fifo_full), 1);
        chk("ovf.flag", 32'(bus.overflow), 1);
        chk("ovf.count", 32'(bus.run_count), 5);
        for (int n = 1; n <= 4; n++) begin
            chk($sformatf("ovf.head%0d", n), 32'(bus.run_len), n);
            step(1'b0, 1'b1, "ovf.pop");
        end
        chk("ovf.drained", 32'(bus.run_valid), 0);
        chk("ovf.sticky", 32'(bus.overflow), 1);

        // Full FIFO: run ends on the same edge as a pop.
        apply_reset("swap");
        for (int n = 1; n <= 4; n++) run(n, 1'b0, "swap");
        run(6, 1'b1, "swap");
        chk("swap.ovf", 32'(bus.overflow), 0);
        chk("swap.full", 32'(bus.fifo_full), 1);
        chk("swap.count", 32'(bus.run_count), 5);
        begin
            int exp_heads[4] = '{2, 3, 4, 6};
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("swap.head%0d", i), 32'(bus.run_len), exp_heads[i]);
                step(1'b0, 1'b1, "swap.pop");
            end
        end

        // One entry stored: push and pop together leave the new run at the head.
        apply_reset("one");
        run(2, 1'b0, "one");
        run(5, 1'b1, "one");
        chk("one.len", 32'(bus.run_len), 5);
        chk("one.valid", 32'(bus.run_valid), 1);
        chk("one.full", 32'(bus.fifo_full), 0);

        // Length saturation.
        apply_reset("sat");
        run(300, 1'b0, "sat");
        chk("sat.len", 32'(bus.run_len), 255);
        chk("sat.count", 32'(bus.run_count), 1);

        // Reset in the middle of a run discards it.
        apply_reset("midrst");
        run(2, 1'b0, "midrst");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "midrst");
        apply_reset("midrst");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "midrst.after");
        chk("midrst.valid", 32'(bus.run_valid), 0);
        chk("midrst.count", 32'(bus.run_count), 0);

        // Reads on an empty FIFO are ignored.
        apply_reset("under");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "under");
        chk("under.valid", 32'(bus.run_valid), 0);
        step(1'b1, 1'b1, "under");
        step(1'b1, 1'b1, "under");
        step(1'b0, 1'b1, "under");
        chk("under.len", 32'(bus.run_len), 2);
        chk("under.valid1", 32'(bus.run_valid), 1);
        step(1'b0, 1'b1, "under");
        chk("under.popped", 32'(bus.run_valid), 0);

        // Random traffic, sparse then heavy reads, with occasional long runs.
        apply_reset("rand");
        for (int i = 0; i < 4000; i++) begin
            bit m, rd;
            int rd_pct;
            rd_pct = (i < 2000) ? 20 : 70;
            m  = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < rd_pct);
            if (i % 1000 == 500) begin
                for (int k = 0; k < 270; k++) step(1'b1, ($urandom_range(0, 1) == 1), "rand.long");
            end
            step(m, rd, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
